// File: rtl/svo_vmon.sv
// svo_vmon: sink for the encoded SVO video stream.
// Measures every frame between start-of-frame beats, compares the
// hsync/vsync edge counts and the active-pixel count against the timing
// parameters, keeps sticky error flags, a lock indicator, a frame counter
// and a 32-bit checksum of the active pixels of the last completed frame.
module svo_vmon #(
  parameter int SVO_HOR_PIXELS     = 640,
  parameter int SVO_VER_PIXELS     = 480,
  parameter int SVO_HOR_TOTAL      = 800,
  parameter int SVO_VER_TOTAL      = 525,
  parameter int SVO_BITS_PER_PIXEL = 18,
  parameter int LOCK_FRAMES        = 2
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          enable,
  input  logic                          clear_err,
  input  logic                          in_axis_tvalid,
  output logic                          in_axis_tready,
  input  logic [SVO_BITS_PER_PIXEL-1:0] in_axis_tdata,
  input  logic [3:0]                    in_axis_tuser,
  output logic                          locked,
  output logic                          err_sof,
  output logic                          err_hsync,
  output logic                          err_vsync,
  output logic                          err_blank,
  output logic [15:0]                   frame_count,
  output logic [31:0]                   frame_sum,
  output logic                          frame_sum_valid
);

  localparam int FRAME_BEATS = SVO_HOR_TOTAL * SVO_VER_TOTAL;
  localparam int ACT_BEATS   = SVO_HOR_PIXELS * SVO_VER_PIXELS;
  localparam int CNT_W       = $clog2(FRAME_BEATS + 1);

  // Reference values, pre-sized to the counter width.
  localparam logic [CNT_W-1:0] FRAME_BEATS_C = CNT_W'(FRAME_BEATS);
  localparam logic [CNT_W-1:0] ACT_BEATS_C   = CNT_W'(ACT_BEATS);
  localparam logic [CNT_W-1:0] HS_EDGES_C    = CNT_W'(SVO_VER_TOTAL);
  localparam logic [CNT_W-1:0] VS_EDGES_C    = CNT_W'(1);
  localparam logic [3:0]       LOCK_C        = 4'(LOCK_FRAMES);

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  // Per-frame measurement counters
  logic [CNT_W-1:0] bcnt;
  logic [CNT_W-1:0] hs_edges;
  logic [CNT_W-1:0] vs_edges;
  logic [CNT_W-1:0] act_cnt;
  logic [31:0]      sum;
  logic [3:0]       clean_cnt;

  // Sync levels of the previous accepted beat, for edge detection
  logic hs_prev;
  logic vs_prev;

  // Beat decode
  logic        beat;
  logic        sof;
  logic        hs_rise;
  logic        vs_rise;
  logic        act;
  logic [31:0] pix;
  logic        at_end;

  // Frame evaluation
  logic       hs_bad;
  logic       vs_bad;
  logic       act_bad;
  logic       frame_bad;
  logic [3:0] clean_next;

  // Control decisions for the current cycle
  logic restart;
  logic accumulate;
  logic frame_done;
  logic sof_err;

  // Clean-frame counter increment, saturating at the lock threshold.
  function automatic logic [3:0] clean_inc(input logic [3:0] cnt);
    if (cnt >= LOCK_C) begin
      return LOCK_C;
    end
    return cnt + 4'd1;
  endfunction

  assign in_axis_tready = enable;

  assign beat    = in_axis_tvalid & enable;
  assign sof     = in_axis_tuser[0];
  assign hs_rise = in_axis_tuser[1] & ~hs_prev;
  assign vs_rise = in_axis_tuser[2] & ~vs_prev;
  assign act     = ~in_axis_tuser[3];
  assign pix     = 32'(in_axis_tdata);
  assign at_end  = (bcnt == FRAME_BEATS_C);

  assign hs_bad     = (hs_edges != HS_EDGES_C);
  assign vs_bad     = (vs_edges != VS_EDGES_C);
  assign act_bad    = (act_cnt != ACT_BEATS_C);
  assign frame_bad  = hs_bad | vs_bad | act_bad;
  assign clean_next = clean_inc(clean_cnt);

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= SEARCH;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and per-beat control decisions
  always_comb begin
    state_nxt  = state;
    restart    = 1'b0;
    accumulate = 1'b0;
    frame_done = 1'b0;
    sof_err    = 1'b0;
    if (beat) begin
      case (state)
        SEARCH: begin
          if (sof) begin
            state_nxt = MEASURE;
            restart   = 1'b1;
          end
        end
        default: begin
          if (sof) begin
            // The sof beat always opens a new frame, timely or not.
            restart = 1'b1;
            if (at_end) begin
              frame_done = 1'b1;
              if (!frame_bad && clean_next == LOCK_C) begin
                state_nxt = LOCKED;
              end else begin
                state_nxt = MEASURE;
              end
            end else begin
              sof_err   = 1'b1;
              state_nxt = MEASURE;
            end
          end else if (at_end) begin
            // Frame is over but no sof arrived: resynchronise from scratch.
            sof_err   = 1'b1;
            state_nxt = SEARCH;
          end else begin
            accumulate = 1'b1;
          end
        end
      endcase
    end
  end

  // Per-frame counters; a restart loads the sof beat's own contribution
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bcnt     <= '0;
      hs_edges <= '0;
      vs_edges <= '0;
      act_cnt  <= '0;
      sum      <= '0;
    end else if (restart) begin
      bcnt     <= CNT_W'(1);
      hs_edges <= CNT_W'(hs_rise);
      vs_edges <= CNT_W'(vs_rise);
      act_cnt  <= CNT_W'(act);
      sum      <= act ? pix : 32'd0;
    end else if (accumulate) begin
      bcnt     <= bcnt + CNT_W'(1);
      hs_edges <= hs_edges + CNT_W'(hs_rise);
      vs_edges <= vs_edges + CNT_W'(vs_rise);
      act_cnt  <= act_cnt + CNT_W'(act);
      sum      <= act ? (sum + pix) : sum;
    end
  end

  // Previous sync samples follow every beat in every state
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hs_prev <= 1'b0;
      vs_prev <= 1'b0;
    end else if (beat) begin
      hs_prev <= in_axis_tuser[1];
      vs_prev <= in_axis_tuser[2];
    end
  end

  // Clean-frame run length and the lock indicator
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      clean_cnt <= '0;
      locked    <= 1'b0;
    end else begin
      if (frame_done) begin
        clean_cnt <= frame_bad ? 4'd0 : clean_next;
      end else if (sof_err) begin
        clean_cnt <= 4'd0;
      end
      locked <= (state_nxt == LOCKED);
    end
  end

  // Completed-frame results: checksum, its strobe and the frame counter
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      frame_sum       <= '0;
      frame_sum_valid <= 1'b0;
      frame_count     <= '0;
    end else begin
      frame_sum_valid <= frame_done;
      if (frame_done) begin
        frame_sum   <= sum;
        frame_count <= frame_count + 16'd1;
      end
    end
  end

  // Sticky error flags; a newly detected error wins over clear_err
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      err_sof   <= 1'b0;
      err_hsync <= 1'b0;
      err_vsync <= 1'b0;
      err_blank <= 1'b0;
    end else begin
      err_sof   <= (err_sof & ~clear_err) | sof_err;
      err_hsync <= (err_hsync & ~clear_err) | (frame_done & hs_bad);
      err_vsync <= (err_vsync & ~clear_err) | (frame_done & vs_bad);
      err_blank <= (err_blank & ~clear_err) | (frame_done & act_bad);
    end
  end

endmodule

// File: tb/tb_svo_vmon.sv
// Directed bench for svo_vmon on a small 8x4 raster (6x3 active).
// Frame checksums and counts are queued when a closing sof is driven
// and checked when frame_sum_valid pulses.
module tb_svo_vmon;

  localparam int HT  = 8;
  localparam int VT  = 4;
  localparam int HP  = 6;
  localparam int VP  = 3;
  localparam int BPP = 18;
  localparam int LF  = 2;

  logic           clk = 1'b0;
  logic           resetn;
  logic           enable;
  logic           clear_err;
  logic           in_axis_tvalid;
  logic           in_axis_tready;
  logic [BPP-1:0] in_axis_tdata;
  logic [3:0]     in_axis_tuser;
  logic           locked;
  logic           err_sof;
  logic           err_hsync;
  logic           err_vsync;
  logic           err_blank;
  logic [15:0]    frame_count;
  logic [31:0]    frame_sum;
  logic           frame_sum_valid;

  int          total = 0;
  int          bad = 0;
  bit          stall = 1'b0;
  int          exp_count;
  logic [31:0] cur_sum;
  logic [47:0] exp_q[$];

  svo_vmon #(
    .SVO_HOR_PIXELS    (HP),
    .SVO_VER_PIXELS    (VP),
    .SVO_HOR_TOTAL     (HT),
    .SVO_VER_TOTAL     (VT),
    .SVO_BITS_PER_PIXEL(BPP),
    .LOCK_FRAMES       (LF)
  ) dut (
    .clk            (clk),
    .resetn         (resetn),
    .enable         (enable),
    .clear_err      (clear_err),
    .in_axis_tvalid (in_axis_tvalid),
    .in_axis_tready (in_axis_tready),
    .in_axis_tdata  (in_axis_tdata),
    .in_axis_tuser  (in_axis_tuser),
    .locked         (locked),
    .err_sof        (err_sof),
    .err_hsync      (err_hsync),
    .err_vsync      (err_vsync),
    .err_blank      (err_blank),
    .frame_count    (frame_count),
    .frame_sum      (frame_sum),
    .frame_sum_valid(frame_sum_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    total++;
    assert (obs === want) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, want);
    end
  endtask

  // Status snapshot after a frame has been sent.
  task automatic chk_status(input string tag, input logic lk, input logic es,
                            input logic eh, input logic ev, input logic eb,
                            input int cnt);
    @(negedge clk);
    chk({tag, ".locked"},      32'(locked),      32'(lk));
    chk({tag, ".err_sof"},     32'(err_sof),     32'(es));
    chk({tag, ".err_hsync"},   32'(err_hsync),   32'(eh));
    chk({tag, ".err_vsync"},   32'(err_vsync),   32'(ev));
    chk({tag, ".err_blank"},   32'(err_blank),   32'(eb));
    chk({tag, ".frame_count"}, 32'(frame_count), 32'(cnt));
  endtask

  // Present one beat and hold it until accepted (bounded).
  task automatic drive_beat(input logic [3:0] user, input logic [BPP-1:0] data, input logic clr);
    int  n;
    bit  done;
    in_axis_tuser = user;
    in_axis_tdata = data;
    clear_err     = clr;
    done = 1'b0;
    n    = 0;
    while (!done && n < 100) begin
      if (stall) begin
        enable         = ~enable;
        in_axis_tvalid = ($urandom_range(0, 2) != 0);
      end else begin
        enable         = 1'b1;
        in_axis_tvalid = 1'b1;
      end
      @(posedge clk);
      done = enable && in_axis_tvalid;
      #1;
      n++;
    end
    in_axis_tvalid = 1'b0;
    clear_err      = 1'b0;
    if (!done) chk("beat_timeout", 32'd0, 32'd1);
  endtask

  // Generate one raster frame (possibly truncated / perturbed).
  task automatic send_frame(input bit sof_on, input int len, input bit boundary,
                            input bit extra_act, input bit extra_vs, input bit clr_on_sof);
    logic [3:0]     user;
    logic [BPP-1:0] data;
    int             line;
    int             col;
    bit             blank;
    if (boundary) begin
      exp_count++;
      exp_q.push_back({16'(exp_count), cur_sum});
    end
    cur_sum = 32'd0;
    for (int i = 0; i < len; i++) begin
      line  = i / HT;
      col   = i % HT;
      blank = !(line < VP && col < HP);
      if (extra_act && line == VT - 1 && col == 0) blank = 1'b0;
      user[0] = sof_on && (i == 0);
      user[1] = (col == 0);
      user[2] = (line == 0) || (extra_vs && line == 2);
      user[3] = blank;
      data    = blank ? '0 : BPP'(1);
      if (!blank) cur_sum = cur_sum + 32'(data);
      drive_beat(user, data, clr_on_sof && (i == 0));
    end
  endtask

  task automatic pulse_clear();
    clear_err = 1'b1;
    @(posedge clk);
    #1;
    clear_err = 1'b0;
  endtask

  // Scoreboard: compare each checksum strobe with the oldest expectation
  always @(negedge clk) begin
    logic [47:0] e;
    if (resetn === 1'b1 && frame_sum_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_sum_valid", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("frame_sum", frame_sum, e[31:0]);
        chk("frame_count_at_sum", 32'(frame_count), 32'(e[47:32]));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn         = 1'b0;
    enable         = 1'b0;
    clear_err      = 1'b0;
    in_axis_tvalid = 1'b0;
    in_axis_tdata  = '0;
    in_axis_tuser  = '0;
    exp_count      = 0;
    cur_sum        = 32'd0;

    // Reset state
    repeat (2) @(posedge clk);
    chk_status("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    chk("reset.frame_sum", frame_sum, 32'd0);
    chk("reset.frame_sum_valid", 32'(frame_sum_valid), 32'd0);
    chk("reset.tready_low", 32'(in_axis_tready), 32'd0);
    enable = 1'b1;
    #1;
    chk("reset.tready_high", 32'(in_axis_tready), 32'd1);
    @(posedge clk);
    #1;
    resetn = 1'b1;
    @(posedge clk);
    #1;

    // Four clean frames, continuous stream
    send_frame(1'b1, 32, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_status("A1", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    send_frame(1'b1, 32, 1'b1, 1'b0, 1'b0, 1'b0);
    chk_status("A2", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1);
    send_frame(1'b1, 32, 1'b1, 1'b0, 1'b0, 1'b0);
    chk_status("A3", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2);
    send_frame(1'b1, 32, 1'b1, 1'b0, 1'b0, 1'b0);
    chk_status("A4", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3);

    // Same stream with enable toggling and random tvalid gaps
    @(posedge clk);
    #1;
    resetn    = 1'b0;
    exp_count = 0;
    cur_sum   = 32'd0;
    @(posedge clk);
    #1;
    resetn = 1'b1;
    stall  = 1'b1;
    send_frame(1'b1, 32, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_status("B1", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    send_frame(1'b1, 32, 1'b1, 1'b0, 1'b0, 1'b0);
    chk_status("B2", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1);
    send_frame(1'b1, 32, 1'b1, 1'b0, 1'b0, 1'b0);
    chk_status("B3", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2);
    send_frame(1'b1, 32, 1'b1, 1'b0, 1'b0, 1'b0);
    chk_status("B4", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3);
    stall  = 1'b0;
    enable = 1'b1;

    // Early sof at beat 20 while locked
    send_frame(1'b1, 20, 1'b1, 1'b0, 1'b0, 1'b0);
    chk_status("C0", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4);
    send_frame(1'b1, 32, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_status("C_early", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4);
    send_frame(1'b1, 32, 1'b1, 1'b0, 1'b0, 1'b0);
    chk_status("C1", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5);
    send_frame(1'b1, 32, 1'b1, 1'b0, 1'b0, 1'b0);
    chk_status("C2", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 6);
    pulse_clear();
    chk_status("C_clr", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6);

    // Missing sof at beat 32
    send_frame(1'b0, 32, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_status("D_miss", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 6);
    pulse_clear();
    send_frame(1'b1, 32, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_status("D0", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6);
    send_frame(1'b1, 32, 1'b1, 1'b0, 1'b0, 1'b0);
    chk_status("D1", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 7);
    send_frame(1'b1, 32, 1'b1, 1'b0, 1'b0, 1'b0);
    chk_status("D2", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8);

    // One extra active pixel in a frame
    send_frame(1'b1, 32, 1'b1, 1'b1, 1'b0, 1'b0);
    chk_status("E0", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 9);
    send_frame(1'b1, 32, 1'b1, 1'b0, 1'b0, 1'b0);
    chk_status("E_blank", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 10);
    pulse_clear();
    chk_status("E_clr", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10);

    // Two vsync edges, clear_err coincident with the closing sof
    send_frame(1'b1, 32, 1'b1, 1'b0, 1'b1, 1'b0);
    chk_status("F0", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 11);
    send_frame(1'b1, 32, 1'b1, 1'b0, 1'b0, 1'b1);
    chk_status("F_vsync", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 12);

    // Asynchronous reset in the middle of a frame
    send_frame(1'b1, 10, 1'b1, 1'b0, 1'b0, 1'b0);
    chk_status("G_pre", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 13);
    @(posedge clk);
    #3;
    resetn = 1'b0;
    #1;
    chk("G.locked", 32'(locked), 32'd0);
    chk("G.err_vsync", 32'(err_vsync), 32'd0);
    chk("G.frame_count", 32'(frame_count), 32'd0);
    chk("G.frame_sum", frame_sum, 32'd0);
    chk("G.frame_sum_valid", 32'(frame_sum_valid), 32'd0);
    chk("G.tready", 32'(in_axis_tready), 32'd1);
    exp_count = 0;
    cur_sum   = 32'd0;
    @(posedge clk);
    #1;
    resetn = 1'b1;
    send_frame(1'b1, 32, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_status("G0", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    send_frame(1'b1, 32, 1'b1, 1'b0, 1'b0, 1'b0);
    chk_status("G1", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1);

    repeat (3) @(negedge clk);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
